// File: rtl/decoder_rr_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : decoder_rr_arbiter_pkg
// Description : Shared state encoding, constants and grant decode helper.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package decoder_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam logic [7:0] GRANT_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Active-low one-hot matching the decoder: index 0 drives bit 7 low.
  function automatic logic [7:0] decode_grant_n(input logic [2:0] idx);
    return ~(8'h80 >> idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_rr_arbiter_rr_priority_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : rr_priority_pick
// Description : Round-robin winner search starting just above last_owner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module rr_priority_pick
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_owner,
  output logic [2:0]       winner,
  output logic             any_req
);

  logic [2:0] start;
  logic [2:0] idx;
  logic       found;

  assign any_req = |req;
  assign start   = last_owner + 3'd1;

  // The 3-bit add wraps naturally, giving the mod-8 rotation.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    idx    = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : decoder_rr_arbiter
// Description : Round-robin owner sequencing of a shared 3-to-8 decoder.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             C,
  output logic             B,
  output logic             A,
  output logic             G,
  output logic [N_REQ-1:0] grant_n,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q,      state_d;
  logic [2:0]       sel_q,        sel_d;
  logic             g_q,          g_d;
  logic [7:0]       grant_n_q,    grant_n_d;
  logic             timeout_q,    timeout_d;
  logic [2:0]       last_owner_q, last_owner_d;
  logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;

  logic [2:0] winner;
  logic       any_req;
  logic       hold_expired;

  rr_priority_pick u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign hold_expired = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    g_d          = g_q;
    grant_n_d    = grant_n_q;
    timeout_d    = 1'b0;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d    = GRANT;
          sel_d      = winner;
          g_d        = 1'b0;
          grant_n_d  = decode_grant_n(winner);
          hold_cnt_d = '0;
        end else begin
          state_d   = IDLE;
          g_d       = 1'b1;
          grant_n_d = GRANT_NONE;
        end
      end
      GRANT: begin
        if (!req[sel_q] || done || hold_expired) begin
          state_d      = GAP;
          g_d          = 1'b1;
          grant_n_d    = GRANT_NONE;
          last_owner_d = sel_q;
          // Owner still wants the bus and did not finish: only the hold limit fired.
          timeout_d    = req[sel_q] && !done;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        g_d       = 1'b1;
        grant_n_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 3'd0;
      g_q          <= 1'b1;
      grant_n_q    <= GRANT_NONE;
      timeout_q    <= 1'b0;
      last_owner_q <= 3'd7;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      g_q          <= g_d;
      grant_n_q    <= grant_n_d;
      timeout_q    <= timeout_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign C       = sel_q[2];
  assign B       = sel_q[1];
  assign A       = sel_q[0];
  assign G       = g_q;
  assign grant_n = grant_n_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_decoder_rr_arbiter
// Description : Directed scenarios for decoder_rr_arbiter (HOLD_MAX=16).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic       C, B, A, G, timeout;
  logic [7:0] grant_n;
  logic [12:0] obs;

  int errors = 0;
  int checks = 0;

  decoder_rr_arbiter #(.HOLD_MAX(16), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .C       (C),
    .B       (B),
    .A       (A),
    .G       (G),
    .grant_n (grant_n),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Observation vector: {G, C,B,A, grant_n, timeout}
  assign obs = {G, C, B, A, grant_n, timeout};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== {1'b1, 3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs, {1'b1, 3'd0, 8'hFF, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== {1'b1, 3'd0, 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL idle_no_req cyc=%0d got=%h want=%h", i, obs, {1'b1, 3'd0, 8'hFF, 1'b0});
      end
    end
  endtask

  task automatic test_single_done();
    do_reset();
    req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {1'b0, 3'd0, 8'h7F, 1'b0}) begin
        errors++;
        $display("FAIL single_grant cyc=%0d got=%h want=%h", i, obs, {1'b0, 3'd0, 8'h7F, 1'b0});
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL single_gap got=%h want=%h", obs, {1'b1, 3'd0, 8'hFF, 1'b0});
    end
    step();
    checks++;
    if (obs !== {1'b0, 3'd0, 8'h7F, 1'b0}) begin
      errors++;
      $display("FAIL single_regrant got=%h want=%h", obs, {1'b0, 3'd0, 8'h7F, 1'b0});
    end
  endtask

  task automatic test_rotation();
    logic [7:0] gn_tab [0:7];
    gn_tab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs !== {1'b0, 3'(k % 8), gn_tab[k % 8], 1'b0}) begin
        errors++;
        $display("FAIL rotation_grant k=%0d got=%h want=%h", k, obs, {1'b0, 3'(k % 8), gn_tab[k % 8], 1'b0});
      end
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (obs !== {1'b1, 3'(k % 8), 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL rotation_gap k=%0d got=%h want=%h", k, obs, {1'b1, 3'(k % 8), 8'hFF, 1'b0});
      end
      step();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (obs !== {1'b0, 3'd4, 8'hF7, 1'b0}) begin
        errors++;
        $display("FAIL hold_grant cyc=%0d got=%h want=%h", i, obs, {1'b0, 3'd4, 8'hF7, 1'b0});
      end
    end
    step();
    checks++;
    if (obs !== {1'b1, 3'd4, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL timeout_pulse got=%h want=%h", obs, {1'b1, 3'd4, 8'hFF, 1'b1});
    end
    step();
    checks++;
    if (obs !== {1'b0, 3'd4, 8'hF7, 1'b0}) begin
      errors++;
      $display("FAIL timeout_regrant got=%h want=%h", obs, {1'b0, 3'd4, 8'hF7, 1'b0});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h40;
    step();
    checks++;
    if (obs !== {1'b0, 3'd6, 8'hFD, 1'b0}) begin
      errors++;
      $display("FAIL wrap_owner6 got=%h want=%h", obs, {1'b0, 3'd6, 8'hFD, 1'b0});
    end
    req = 8'h81;
    step();
    checks++;
    if (obs !== {1'b1, 3'd6, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL wrap_drop_gap got=%h want=%h", obs, {1'b1, 3'd6, 8'hFF, 1'b0});
    end
    step();
    checks++;
    if (obs !== {1'b0, 3'd7, 8'hFE, 1'b0}) begin
      errors++;
      $display("FAIL wrap_grant7 got=%h want=%h", obs, {1'b0, 3'd7, 8'hFE, 1'b0});
    end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    checks++;
    if (obs !== {1'b0, 3'd0, 8'h7F, 1'b0}) begin
      errors++;
      $display("FAIL wrap_grant0 got=%h want=%h", obs, {1'b0, 3'd0, 8'h7F, 1'b0});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 8'h02;
    step();
    checks++;
    if (obs !== {1'b0, 3'd1, 8'hBF, 1'b0}) begin
      errors++;
      $display("FAIL simul_grant got=%h want=%h", obs, {1'b0, 3'd1, 8'hBF, 1'b0});
    end
    req  = 8'h00;
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd1, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL simul_release got=%h want=%h", obs, {1'b1, 3'd1, 8'hFF, 1'b0});
    end
    step();
    checks++;
    if (obs !== {1'b1, 3'd1, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL simul_idle got=%h want=%h", obs, {1'b1, 3'd1, 8'hFF, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h08;
    step();
    checks++;
    if (obs !== {1'b0, 3'd3, 8'hEF, 1'b0}) begin
      errors++;
      $display("FAIL areset_grant3 got=%h want=%h", obs, {1'b0, 3'd3, 8'hEF, 1'b0});
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL areset_immediate got=%h want=%h", obs, {1'b1, 3'd0, 8'hFF, 1'b0});
    end
    req = 8'h0C;
    #1 reset = 1'b0;
    step();
    checks++;
    if (obs !== {1'b0, 3'd2, 8'hDF, 1'b0}) begin
      errors++;
      $display("FAIL areset_first_grant got=%h want=%h", obs, {1'b0, 3'd2, 8'hDF, 1'b0});
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    test_reset();
    test_single_done();
    test_rotation();
    test_timeout();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
